mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch
// and data ports, one access at a time, with a fetch anti-starvation cap.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t     state;
  logic       owner_d;
  logic [3:0] wcnt;
  logic [3:0] streak;
  logic       pick_d;

  // Data wins ties unless fetch has waited out the full streak.
  always_comb begin
    pick_d = d_req & (~i_req | (streak != LIM));
  end

  assign busy = (state != IDLE);

  // Access sequencer with registered memory and requester outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      wcnt    <= '0;
      streak  <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
    end else begin
      m_req  <= 1'b0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req | d_req) begin
            owner_d <= pick_d;
            m_req   <= 1'b1;
            state   <= ISSUE;
            if (pick_d) begin
              m_addr  <= d_addr;
              m_we    <= d_we;
              m_wdata <= d_wdata;
              if (!i_req)
                streak <= '0;
              else if (streak != LIM)
                streak <= streak + 4'd1;
            end else begin
              m_addr  <= i_addr;
              m_we    <= 1'b0;
              m_wdata <= '0;
              streak  <= '0;
            end
          end
        end
        ISSUE: begin
          wcnt  <= LAT;
          state <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1) begin
            state <= DONE;
            if (owner_d) begin
              d_rdata <= m_we ? '0 : m_rdata;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= m_rdata;
              i_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences
// for contention, starvation, dropped request and mid-access reset.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        busy;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .LATENCY(LAT),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_rdata(i_rdata),
    .i_done(i_done),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_done(d_done),
    .m_req(m_req),
    .m_we(m_we),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // memory model: two-stage read pipe gives data LAT cycles after m_req
  logic [31:0] mem [64];
  logic [31:0] p1 = '0;
  always @(posedge clk) begin
    if (m_req && m_we)
      mem[m_addr[7:2]] <= m_wdata;
    p1 <= (m_req && !m_we) ? mem[m_addr[7:2]] : 32'hBAD0BAD0;
    m_rdata <= p1;
  end

  // grant log (data addresses >= 0x80) and done-pulse monitor
  logic [7:0] glog [$];
  int icnt = 0;
  int dcnt = 0;
  int dbl = 0;
  int streak_at_i = 99;
  logic prev_i = 1'b0;
  logic prev_d = 1'b0;
  always @(negedge clk) begin
    if (m_req) begin
      glog.push_back(m_addr[7] ? 8'h44 : 8'h49);
      if (!m_addr[7])
        streak_at_i = int'(dut.streak);
    end
    if (i_done) icnt++;
    if (d_done) dcnt++;
    if ((i_done && prev_i) || (d_done && prev_d)) dbl++;
    prev_i = i_done;
    prev_d = d_done;
  end

  function automatic logic [7:0] gat(input int k);
    if (k < glog.size())
      return glog[k];
    return 8'h3F;
  endfunction

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        own_d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int reqc = -1;
    int donec = -1;
    logic [31:0] ea;
    logic        ew;
    ea = v.own_d ? v.da : v.ia;
    ew = v.own_d & v.dw;
    i_req = v.ir;
    i_addr = v.ia;
    d_req = v.dr;
    d_we = v.dw;
    d_addr = v.da;
    d_wdata = v.dwd;
    for (int c = 1; c <= 12 && donec < 0; c++) begin
      @(negedge clk);
      if (m_req && reqc < 0) begin
        reqc = c;
        chk($sformatf("v%0d_maddr", n), m_addr, ea);
        chk($sformatf("v%0d_mwe", n), 32'(m_we), 32'(ew));
        if (ew)
          chk($sformatf("v%0d_mwdata", n), m_wdata, v.dwd);
      end
      if (i_done || d_done) begin
        donec = c;
        chk($sformatf("v%0d_owner", n), {30'd0, i_done, d_done},
            v.own_d ? 32'd1 : 32'd2);
        chk($sformatf("v%0d_rdata", n),
            v.own_d ? d_rdata : i_rdata, v.exp);
        chk($sformatf("v%0d_busy", n), 32'(busy), 32'd1);
      end
    end
    chk($sformatf("v%0d_req_cyc", n), reqc, 1);
    chk($sformatf("v%0d_done_cyc", n), donec, LAT + 2);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_done_w", n), {30'd0, i_done, d_done}, 32'd0);
    chk($sformatf("v%0d_hold", n),
        v.own_d ? d_rdata : i_rdata, v.exp);
    chk($sformatf("v%0d_idle", n), 32'(busy), 32'd0);
  endtask

  initial begin
    int gb, ib, db, xb, dd;
    logic di, dn;
    string exp_ord;

    for (int i = 0; i < 64; i++)
      mem[i] = 32'h1000_0000 + i;
    mem[4] = 32'h13;

    tbl[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h13};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF, 1'b1, 32'h0};
    tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 32'h14, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h10000008};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hFC, 32'hA5A5A5A5, 1'b1, 32'h0};
    tbl[6] = '{1'b1, 32'hFC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hA5A5A5A5};
    tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h10000000};

    rst = 1'b1;
    i_req = 1'b0;
    i_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    @(negedge clk);
    chk("reset_outs",
        32'(|{i_rdata, d_rdata, i_done, d_done, m_req, m_we,
              m_addr, m_wdata, busy}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++)
      run_vec(tbl[k], k);

    // contention: data first, fetch second, requests held through DONE
    do_reset();
    gb = glog.size();
    ib = icnt;
    db = dcnt;
    xb = dbl;
    i_addr = 32'h40;
    d_addr = 32'h84;
    d_we = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int c = 0; c < 40 && (i_req || d_req); c++) begin
      @(negedge clk);
      di = i_done;
      dn = d_done;
      if (di || dn) begin
        @(posedge clk);
        #1;
        if (di) i_req = 1'b0;
        if (dn) d_req = 1'b0;
      end
    end
    repeat (8) @(negedge clk);
    chk("cont_ngrants", glog.size() - gb, 2);
    chk("cont_first", 32'(gat(gb)), 32'h44);
    chk("cont_second", 32'(gat(gb + 1)), 32'h49);
    chk("cont_idone", icnt - ib, 1);
    chk("cont_ddone", dcnt - db, 1);
    chk("cont_dbl", dbl - xb, 0);

    // starvation: data always pending, fetch held until served
    do_reset();
    gb = glog.size();
    ib = icnt;
    i_addr = 32'h40;
    d_addr = 32'h88;
    d_we = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int c = 0; c < 200 && (glog.size() - gb) < 6; c++) begin
      @(negedge clk);
      if (i_done) begin
        @(posedge clk);
        #1;
        i_req = 1'b0;
      end
    end
    d_req = 1'b0;
    repeat (10) @(negedge clk);
    exp_ord = "DDDDID";
    for (int k = 0; k < 6; k++)
      chk($sformatf("starve_g%0d", k), 32'(gat(gb + k)), 32'(exp_ord[k]));
    chk("starve_streak", streak_at_i, 0);
    chk("starve_idone", icnt - ib, 1);

    // dropped data request mid-WAIT, fetch served next
    do_reset();
    i_addr = 32'h44;
    d_addr = 32'h8C;
    d_we = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) chk("drop_dgrant", m_addr, 32'h8C);
      if (c == 2) d_req = 1'b0;
      if (c == 4) begin
        chk("drop_ddone", 32'(d_done), 32'd1);
        chk("drop_drdata", d_rdata, 32'h10000023);
      end
      if (c == 6) begin
        chk("drop_ireq", 32'(m_req), 32'd1);
        chk("drop_iaddr", m_addr, 32'h44);
      end
      if (c == 9) begin
        chk("drop_idone", 32'(i_done), 32'd1);
        chk("drop_irdata", i_rdata, 32'h10000011);
      end
    end
    @(posedge clk);
    #1;
    i_req = 1'b0;
    @(negedge clk);

    // reset asserted mid-WAIT of a data read
    d_addr = 32'h90;
    d_we = 1'b0;
    d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    chk("rst_pre_addr", m_addr, 32'h90);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_outs_async",
        32'(|{i_rdata, d_rdata, i_done, d_done, m_req, m_we,
              m_addr, m_wdata, busy}), 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_done) dd++;
    end
    chk("rst_no_done", dd, 0);
    chk("rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
